subservient_dbg_bridge: RTL and testbench
=========================================

// Module: subservient_dbg_bridge
// PURPOSE
//  Wishbone slave on the Caravel wbs bus; feeds the subservient debug port (i_wb_dbg_*, i_debug_mode).
//  Decodes one address window. Forwards memory-page accesses to the debug port; serves a small CSR page locally.
//  Adds a response timeout so a stalled core never hangs the management SoC.
// PARAMETERS
//  BASE_ADR  32'h3000_0000  window base; compare uses adr[31:WIN_AW]
//  WIN_AW    16             window size 2**WIN_AW bytes; adr[WIN_AW-1]=1 selects CSR page
//  TMO_CYC   255            cycles to wait for o_wb_dbg_ack before error response (>=2)
// PORTS
//  wb_clk_i      in   1   clock
//  wb_rst_ni     in   1   reset, asynchronous, active-low
//  wbs_stb_i     in   1   host strobe
//  wbs_cyc_i     in   1   host cycle
//  wbs_we_i      in   1   host write enable
//  wbs_sel_i     in   4   host byte selects
//  wbs_adr_i     in   32  host byte address
//  wbs_dat_i     in   32  host write data
//  wbs_ack_o     out  1   host acknowledge, one-cycle pulse
//  wbs_dat_o     out  32  host read data, valid with ack
//  dbg_adr_o     out  32  to i_wb_dbg_adr: {zeros, adr[WIN_AW-2:0]}
//  dbg_dat_o     out  32  to i_wb_dbg_dat
//  dbg_sel_o     out  4   to i_wb_dbg_sel
//  dbg_we_o      out  1   to i_wb_dbg_we
//  dbg_stb_o     out  1   to i_wb_dbg_stb
//  dbg_rdt_i     in   32  from o_wb_dbg_rdt
//  dbg_ack_i     in   1   from o_wb_dbg_ack
//  debug_mode_o  out  1   to i_debug_mode (CTRL.dbg_en)
// BEHAVIOUR
//  Reset: wbs_ack_o=0, wbs_dat_o=0, dbg_*_o=0, debug_mode_o=1 (core held in debug), CSRs reset, FSM=IDLE.
//  hit = stb & cyc & (adr[31:WIN_AW]==BASE_ADR[31:WIN_AW]); non-hits are ignored (never acked).
//  FSM IDLE: hit & CSR page -> RESP (CSR read/write done this edge); hit & mem page & dbg_en -> REQ, latch adr/dat/sel/we
//   onto dbg_*_o, dbg_stb_o=1, timer=0; hit & mem page & !dbg_en -> RESP with rdata 0, write dropped, STATUS.denied=1.
//  REQ: dbg_stb_o held, dbg_* stable. dbg_ack_i -> latch dbg_rdt_i, dbg_stb_o=0, -> RESP.
//   timer==TMO_CYC-1 without ack -> rdata 32'hDEAD_BEEF, dbg_stb_o=0, STATUS.tmo=1, -> RESP. ack on that same edge wins.
//  RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o; -> IDLE. Host stb in the cycle after ack is not re-sampled
//   as new (RESP->IDLE consumes it). Latency: CSR 2 edges; forwarded = 1 + debug-port latency + 1.
//  Host drops cyc during REQ: transaction completes on debug side, ack still issued (harmless per Wishbone classic).
//  Async reset mid-REQ: dbg_stb_o drops immediately; no ack issued.
//  CSR page (offset within page, word aligned, sel ignored):
//   0x0 CTRL   rw  [0] dbg_en (reset 1); others read 0
//   0x4 STATUS     [0] tmo, [1] denied: sticky, write-1-to-clear; [31:16] txn_cnt ro, +1 per forwarded ack, wraps 16'hFFFF->0
//   other offsets: read 0, writes ignored, still acked.
//  Status set and W1C on same edge: set wins.
//  Timer width $clog2(TMO_CYC+1); txn_cnt counts only acked-by-core transfers, not timeouts/denied.
// STRUCTURE
//  Package subservient_dbg_pkg: FSM state enum (IDLE, REQ, RESP), CSR offsets, DEAD_BEEF constant, CTRL/STATUS bit indices.
//  One sub-module natural: subservient_dbg_csr (CTRL/STATUS regs, W1C, txn counter); FSM and timer in top.
// TESTING
//  1 Reset release: all outputs 0 except debug_mode_o=1; read CTRL @0x3000_8000 -> 32'h1, ack after 2 edges.
//  2 Mem write 0x3000_0010=0xA5A5_5A5A sel=4'hF: dbg_adr_o=0x10, dbg_stb_o until dbg_ack_i (3-cycle model), one host ack,
//    STATUS[31:16]=1.
//  3 Write CTRL=0, then mem read 0x3000_0004: no dbg_stb_o, ack with 0, STATUS=0x0001_0002 after test 2; W1C 0x2 -> 0x0001_0000.
//  4 Core never acks: ack at TMO_CYC+1 edges after request with 0xDEAD_BEEF, STATUS.tmo=1; ack arriving on the timeout
//    edge -> real rdata, tmo stays 0.
//  5 Address 0x3001_0000 and 0x2000_0000 with stb/cyc: no ack, no dbg_stb_o for 20 cycles.
//  6 Assert wb_rst_ni low mid-REQ: dbg_stb_o low asynchronously, no ack; after release CTRL=1, STATUS=0.

Source files
------------

// File: rtl/subservient_dbg_pkg.sv
// Shared types and constants for the subservient debug-port Wishbone bridge.
package subservient_dbg_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [31:0] CSR_CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] CSR_STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] DEAD_BEEF      = 32'hDEAD_BEEF;

    localparam int CTRL_DBG_EN   = 0;
    localparam int STATUS_TMO    = 0;
    localparam int STATUS_DENIED = 1;
endpackage

// File: rtl/subservient_dbg_csr.sv
// CTRL/STATUS register page: debug-enable, sticky W1C error flags, forwarded-transfer counter.
module subservient_dbg_csr
    import subservient_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] ofs,
    input  logic [1:0]  wbits,
    input  logic        set_tmo,
    input  logic        set_denied,
    input  logic        inc_txn,
    output logic [31:0] rdata,
    output logic        dbg_en
);
    logic        tmo;
    logic        denied;
    logic [15:0] txn_cnt;
    logic        ctrl_sel;
    logic        status_sel;
    logic        clr_tmo;
    logic        clr_denied;

    assign ctrl_sel   = (ofs & ~32'h3) == CSR_CTRL_OFS;
    assign status_sel = (ofs & ~32'h3) == CSR_STATUS_OFS;
    assign clr_tmo    = wr_en & status_sel & wbits[STATUS_TMO];
    assign clr_denied = wr_en & status_sel & wbits[STATUS_DENIED];

    always_comb begin
        rdata = '0;
        if (ctrl_sel) begin
            rdata[CTRL_DBG_EN] = dbg_en;
        end else if (status_sel) begin
            rdata[STATUS_TMO]    = tmo;
            rdata[STATUS_DENIED] = denied;
            rdata[31:16]         = txn_cnt;
        end
    end

    // A set arriving on the same edge as its W1C keeps the flag raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_en  <= 1'b1;
            tmo     <= 1'b0;
            denied  <= 1'b0;
            txn_cnt <= '0;
        end else begin
            if (wr_en && ctrl_sel) dbg_en <= wbits[CTRL_DBG_EN];
            tmo    <= set_tmo    | (tmo    & ~clr_tmo);
            denied <= set_denied | (denied & ~clr_denied);
            if (inc_txn) txn_cnt <= txn_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/subservient_dbg_bridge.sv
// Wishbone slave bridging the Caravel wbs bus onto the subservient debug port,
// with a local CSR page and a response timeout guarding against a stalled core.
module subservient_dbg_bridge
    import subservient_dbg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          WIN_AW   = 16,
    parameter int          TMO_CYC  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] dbg_adr_o,
    output logic [31:0] dbg_dat_o,
    output logic [3:0]  dbg_sel_o,
    output logic        dbg_we_o,
    output logic        dbg_stb_o,
    input  logic [31:0] dbg_rdt_i,
    input  logic        dbg_ack_i,
    output logic        debug_mode_o
);
    localparam int          TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [31:0] OFS_MASK = (32'd1 << (WIN_AW - 1)) - 32'd1;

    state_t        state;
    logic [TW-1:0] timer;
    logic [31:0]   resp_dat;
    logic [31:0]   csr_rdata;
    logic [31:0]   page_ofs;
    logic          hit;
    logic          csr_page;
    logic          accept;
    logic          timeout;

    assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:WIN_AW] == BASE_ADR[31:WIN_AW]);
    assign csr_page = wbs_adr_i[WIN_AW-1];
    assign page_ofs = wbs_adr_i & OFS_MASK;
    // While ack is high the host strobe still belongs to the finished transfer.
    assign accept   = (state == IDLE) & hit & ~wbs_ack_o;
    assign timeout  = (state == REQ) & ~dbg_ack_i & (timer == TMO_LAST);

    subservient_dbg_csr u_csr (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .wr_en      (accept & csr_page & wbs_we_i),
        .ofs        (page_ofs),
        .wbits      (wbs_dat_i[1:0]),
        .set_tmo    (timeout),
        .set_denied (accept & ~csr_page & ~debug_mode_o),
        .inc_txn    ((state == REQ) & dbg_ack_i),
        .rdata      (csr_rdata),
        .dbg_en     (debug_mode_o)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            timer     <= '0;
            resp_dat  <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            dbg_adr_o <= '0;
            dbg_dat_o <= '0;
            dbg_sel_o <= '0;
            dbg_we_o  <= 1'b0;
            dbg_stb_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (accept) begin
                        if (csr_page) begin
                            resp_dat <= csr_rdata;
                            state    <= RESP;
                        end else if (debug_mode_o) begin
                            dbg_adr_o <= page_ofs;
                            dbg_dat_o <= wbs_dat_i;
                            dbg_sel_o <= wbs_sel_i;
                            dbg_we_o  <= wbs_we_i;
                            dbg_stb_o <= 1'b1;
                            timer     <= '0;
                            state     <= REQ;
                        end else begin
                            resp_dat <= '0;
                            state    <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (dbg_ack_i) begin
                        resp_dat  <= dbg_rdt_i;
                        dbg_stb_o <= 1'b0;
                        state     <= RESP;
                    end else if (timeout) begin
                        resp_dat  <= DEAD_BEEF;
                        dbg_stb_o <= 1'b0;
                        state     <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= resp_dat;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subservient_dbg_bridge.sv
// Self-checking bench: scenario tasks plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_subservient_dbg_bridge;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] CSR_BASE = 32'h3000_8000;
    localparam int          TMO      = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] dbg_adr, dbg_dat;
    logic [3:0]  dbg_sel;
    logic        dbg_we, dbg_stb;
    logic [31:0] dbg_rdt;
    logic        dbg_ack;
    logic        debug_mode;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit          m_en = 1'b1, m_tmo = 1'b0, m_denied = 1'b0;
    logic [15:0] m_txn = 16'h0;
    logic [31:0] ref_mem[int];

    // Debug-port responder state
    int          core_lat = 0;
    int          stb_cycles = 0;
    logic [31:0] core_mem[int];
    logic [31:0] seen_adr = 32'h0, seen_dat = 32'h0;
    logic [3:0]  seen_sel = 4'h0;
    logic        seen_we = 1'b0;

    always #5 clk = ~clk;

    subservient_dbg_bridge #(.BASE_ADR(BASE), .WIN_AW(16), .TMO_CYC(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .dbg_adr_o(dbg_adr), .dbg_dat_o(dbg_dat), .dbg_sel_o(dbg_sel), .dbg_we_o(dbg_we),
        .dbg_stb_o(dbg_stb), .dbg_rdt_i(dbg_rdt), .dbg_ack_i(dbg_ack), .debug_mode_o(debug_mode)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = nw[8*i +: 8];
        return old;
    endfunction

    // Memory-like core: acks core_lat negedges after seeing the strobe; core_lat<0 never acks.
    initial begin : core
        int wcnt;
        int key;
        wcnt = 0;
        dbg_ack = 1'b0;
        dbg_rdt = 32'h0;
        forever begin
            @(negedge clk);
            if (dbg_ack) begin
                dbg_ack = 1'b0;
                wcnt = 0;
            end else if (dbg_stb === 1'b1) begin
                stb_cycles++;
                if (core_lat >= 0 && wcnt == core_lat) begin
                    seen_adr = dbg_adr; seen_dat = dbg_dat; seen_sel = dbg_sel; seen_we = dbg_we;
                    key = int'(dbg_adr & 32'h7FFC);
                    if (dbg_we) begin
                        core_mem[key] = merge(core_mem.exists(key) ? core_mem[key] : 32'h0, dbg_dat, dbg_sel);
                        dbg_rdt = 32'h0;
                    end else begin
                        dbg_rdt = core_mem.exists(key) ? core_mem[key] : 32'h0;
                    end
                    dbg_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Transaction-level expectation for one host access; updates the model state.
    task automatic ref_access(input logic [31:0] a_adr, input logic a_we, input logic [31:0] a_dat,
                              input logic [3:0] a_sel, input int lat,
                              output logic [31:0] exp_rd, output int exp_edges, output int exp_stb);
        int key;
        key = int'(a_adr & 32'h7FFC);
        exp_rd = 32'h0;
        exp_stb = 0;
        if (a_adr[15]) begin
            exp_edges = 2;
            if (key == 0) exp_rd = {31'h0, m_en};
            else if (key == 4) exp_rd = {m_txn, 14'h0, m_denied, m_tmo};
            if (a_we && key == 0) m_en = a_dat[0];
            if (a_we && key == 4) begin
                if (a_dat[0]) m_tmo = 1'b0;
                if (a_dat[1]) m_denied = 1'b0;
            end
        end else if (!m_en) begin
            exp_edges = 2;
            m_denied = 1'b1;
        end else if (lat >= 0 && lat < TMO) begin
            exp_edges = lat + 3;
            exp_stb = lat + 1;
            exp_rd = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            if (a_we) ref_mem[key] = merge(exp_rd, a_dat, a_sel);
            m_txn = m_txn + 16'd1;
        end else begin
            exp_edges = TMO + 2;
            exp_stb = TMO;
            exp_rd = 32'hDEAD_BEEF;
            m_tmo = 1'b1;
        end
    endtask

    // Host master: drive, wait for ack (bounded), optionally keep strobe one extra cycle,
    // then watch two idle cycles for any spurious ack or debug strobe.
    task automatic xfer(input logic [31:0] a_adr, input logic a_we, input logic [31:0] a_dat,
                        input logic [3:0] a_sel, input bit hold,
                        output logic [31:0] r_dat, output int edges, output bit acked, output bit extra);
        @(negedge clk);
        adr = a_adr; we = a_we; wdat = a_dat; sel = a_sel; stb = 1'b1; cyc = 1'b1;
        edges = 0; acked = 1'b0; r_dat = 32'h0; extra = 1'b0;
        while (!acked && edges < TMO + 20) begin
            @(posedge clk); @(negedge clk);
            edges++;
            if (ack === 1'b1) begin acked = 1'b1; r_dat = rdat; end
        end
        if (hold) begin
            @(posedge clk); @(negedge clk);
            extra |= (ack === 1'b1) || (dbg_stb === 1'b1);
        end
        stb = 1'b0; cyc = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            extra |= (ack === 1'b1) || (dbg_stb === 1'b1);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r, er; int e, ee, es; bit a, x;
        n_checks++; if (ack !== 1'b0 || rdat !== 32'h0) begin n_fail++; $display("FAIL reset_host: ack=%b dat=%h required 0/00000000", ack, rdat); end
        n_checks++; if ({dbg_adr, dbg_dat, dbg_sel, dbg_we, dbg_stb} !== 70'h0) begin n_fail++; $display("FAIL reset_dbg: adr=%h dat=%h sel=%h we=%b stb=%b required all 0", dbg_adr, dbg_dat, dbg_sel, dbg_we, dbg_stb); end
        n_checks++; if (debug_mode !== 1'b1) begin n_fail++; $display("FAIL reset_debug_mode: got %b required 1", debug_mode); end
        @(negedge clk); rst_n = 1'b1;
        ref_access(CSR_BASE, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (!a || r !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl_read: acked=%b dat=%h required 00000001", a, r); end
        n_checks++; if (e != 2) begin n_fail++; $display("FAIL reset_ctrl_latency: got %0d edges required 2", e); end
    endtask

    task automatic test_mem_write();
        logic [31:0] r, er; int e, ee, es, s0; bit a, x;
        core_lat = 2; s0 = stb_cycles;
        ref_access(BASE | 32'h10, 1'b1, 32'hA5A5_5A5A, 4'hF, 2, er, ee, es);
        xfer(BASE | 32'h10, 1'b1, 32'hA5A5_5A5A, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (seen_adr !== 32'h10 || seen_dat !== 32'hA5A5_5A5A || seen_sel !== 4'hF || seen_we !== 1'b1) begin
            n_fail++; $display("FAIL memwr_dbg_side: adr=%h dat=%h sel=%h we=%b required 00000010/a5a55a5a/f/1", seen_adr, seen_dat, seen_sel, seen_we); end
        n_checks++; if (stb_cycles - s0 != es) begin n_fail++; $display("FAIL memwr_stb_hold: %0d strobe cycles required %0d", stb_cycles - s0, es); end
        n_checks++; if (!a || e != ee || x) begin n_fail++; $display("FAIL memwr_ack: acked=%b edges=%0d extra=%b required 1/%0d/0", a, e, x, ee); end
        ref_access(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== 32'h0001_0000 || r !== er) begin n_fail++; $display("FAIL memwr_status: got %h required 00010000", r); end
    endtask

    task automatic test_denied();
        logic [31:0] r, er; int e, ee, es, s0; bit a, x;
        ref_access(CSR_BASE, 1'b1, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE, 1'b1, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (debug_mode !== 1'b0) begin n_fail++; $display("FAIL denied_mode: got %b required 0", debug_mode); end
        s0 = stb_cycles;
        ref_access(BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1, er, ee, es);
        xfer(BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (!a || r !== 32'h0 || e != 2 || stb_cycles != s0) begin
            n_fail++; $display("FAIL denied_read: acked=%b dat=%h edges=%0d strobes=%0d required 1/0/2/0", a, r, e, stb_cycles - s0); end
        ref_access(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== 32'h0001_0002 || r !== er) begin n_fail++; $display("FAIL denied_status: got %h required 00010002", r); end
        ref_access(CSR_BASE | 32'h4, 1'b1, 32'h2, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b1, 32'h2, 4'hF, 1'b0, r, e, a, x);
        ref_access(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL denied_w1c: got %h required 00010000", r); end
        ref_access(CSR_BASE, 1'b1, 32'h1, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE, 1'b1, 32'h1, 4'hF, 1'b0, r, e, a, x);
    endtask

    task automatic test_timeout();
        logic [31:0] r, er; int e, ee, es; bit a, x;
        core_lat = -1;
        ref_access(BASE | 32'h40, 1'b0, 32'h0, 4'hF, -1, er, ee, es);
        xfer(BASE | 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (!a || r !== 32'hDEAD_BEEF || e != TMO + 2) begin
            n_fail++; $display("FAIL tmo_resp: acked=%b dat=%h edges=%0d required 1/deadbeef/%0d", a, r, e, TMO + 2); end
        ref_access(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== er || r[0] !== 1'b1) begin n_fail++; $display("FAIL tmo_status: got %h required %h", r, er); end
        ref_access(CSR_BASE | 32'h4, 1'b1, 32'h1, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b1, 32'h1, 4'hF, 1'b0, r, e, a, x);
        core_lat = TMO - 1;
        ref_access(BASE | 32'h10, 1'b0, 32'h0, 4'hF, TMO - 1, er, ee, es);
        xfer(BASE | 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (!a || r !== 32'hA5A5_5A5A || e != TMO + 2) begin
            n_fail++; $display("FAIL tmo_edge_ack: acked=%b dat=%h edges=%0d required 1/a5a55a5a/%0d", a, r, e, TMO + 2); end
        ref_access(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== er || r[0] !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_status: got %h required %h", r, er); end
    endtask

    task automatic test_window();
        logic [31:0] miss [2];
        bit seen;
        miss[0] = 32'h3001_0000; miss[1] = 32'h2000_0000;
        core_lat = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            adr = miss[k]; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
            seen = 1'b0;
            repeat (20) begin
                @(posedge clk); @(negedge clk);
                seen |= (ack !== 1'b0) || (dbg_stb !== 1'b0);
            end
            stb = 1'b0; cyc = 1'b0;
            n_checks++; if (seen) begin n_fail++; $display("FAIL window_miss: address %h got a response, required none", miss[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er; int e, ee, es; bit a, x;
        core_lat = 1;
        ref_access(CSR_BASE, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE, 1'b0, 32'h0, 4'hF, 1'b1, r, e, a, x);
        n_checks++; if (!a || r !== er || x) begin n_fail++; $display("FAIL b2b_csr_hold: acked=%b dat=%h extra=%b required 1/%h/0", a, r, x, er); end
        ref_access(BASE | 32'h10, 1'b0, 32'h0, 4'hF, 1, er, ee, es);
        xfer(BASE | 32'h10, 1'b0, 32'h0, 4'hF, 1'b1, r, e, a, x);
        n_checks++; if (!a || r !== er || e != ee || x) begin n_fail++; $display("FAIL b2b_mem_hold: acked=%b dat=%h edges=%0d extra=%b required 1/%h/%0d/0", a, r, e, x, er, ee); end
    endtask

    task automatic test_random();
        logic [31:0] r, er, ra, rd; int e, ee, es, s0, lat, kind; bit a, x, h; logic rw; logic [3:0] rs;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            lat = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 6);
            h = $urandom_range(0, 1);
            rd = $urandom; rs = 4'($urandom_range(1, 15)); rw = 1'b0;
            case (kind)
                0: ra = CSR_BASE | (($urandom_range(0, 3) == 0) ? 32'h10 : 32'h0);
                1: ra = CSR_BASE | 32'h4;
                2: begin ra = CSR_BASE | 32'h4; rw = 1'b1; rd = 32'($urandom_range(0, 3)); end
                3: begin ra = CSR_BASE; rw = 1'b1; rd = {31'h0, ($urandom_range(0, 3) != 0)}; end
                4, 5, 6: begin ra = BASE | (32'($urandom_range(0, 7)) << 2); rw = 1'b1; end
                default: ra = BASE | (32'($urandom_range(0, 7)) << 2);
            endcase
            core_lat = lat; s0 = stb_cycles;
            ref_access(ra, rw, rd, rs, lat, er, ee, es);
            xfer(ra, rw, rd, rs, h, r, e, a, x);
            n_checks++; if (!a || e != ee) begin n_fail++; $display("FAIL rand_ack it%0d adr=%h: acked=%b edges=%0d required 1/%0d", it, ra, a, e, ee); end
            if (!rw) begin
                n_checks++; if (r !== er) begin n_fail++; $display("FAIL rand_rdata it%0d adr=%h: got %h required %h", it, ra, r, er); end
            end
            n_checks++; if (stb_cycles - s0 != es || x) begin n_fail++; $display("FAIL rand_dbg it%0d adr=%h: strobes=%0d extra=%b required %0d/0", it, ra, stb_cycles - s0, x, es); end
        end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] r, er; int e, ee, es, acks; bit a, x;
        core_lat = -1;
        @(negedge clk);
        adr = BASE | 32'h20; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (dbg_stb !== 1'b1) begin n_fail++; $display("FAIL midreq_stb_active: got %b required 1", dbg_stb); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (dbg_stb !== 1'b0) begin n_fail++; $display("FAIL midreq_stb_async: got %b required 0", dbg_stb); end
        stb = 1'b0; cyc = 1'b0;
        acks = 0;
        repeat (4) begin @(negedge clk); if (ack !== 1'b0) acks++; end
        rst_n = 1'b1;
        m_en = 1'b1; m_tmo = 1'b0; m_denied = 1'b0; m_txn = 16'h0;
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL midreq_no_ack: %0d acks required 0", acks); end
        core_lat = 1;
        ref_access(CSR_BASE, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL midreq_ctrl: got %h required 00000001", r); end
        ref_access(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 0, er, ee, es);
        xfer(CSR_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, r, e, a, x);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL midreq_status: got %h required 00000000", r); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_mem_write();
        test_denied();
        test_timeout();
        test_window();
        test_back_to_back();
        test_random();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
